// File: rtl/shared_mem_rr_arbiter.sv
// Round-robin arbiter and sequencer for one shared BRAM port serving NUM_CORES cores.
// Optional bus-lock FSM for atomic read-modify-write: define SHMEM_ARB_LOCK_EN.
module shared_mem_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        we_i,
  input  logic [NUM_CORES-1:0]        lock_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_i,
  output logic [NUM_CORES-1:0]        wait_o,
  output logic [NUM_CORES-1:0]        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int NSTG  = RD_LAT + 1;
  localparam logic [CID_W:0] NUM_CORES_W = (CID_W+1)'(NUM_CORES);
  localparam logic [CID_W-1:0] LAST_ID   = CID_W'(NUM_CORES - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [CID_W-1:0]     ptr_reg;
  logic [CID_W-1:0]     ptr_next;
  logic                 ptr_update;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] gnt;
  logic                 gnt_valid;
  logic [CID_W-1:0]     gnt_id;
  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0] rot;
  logic [CID_W-1:0]     offset;
  logic [CID_W:0]       sum;

  // Rotate the eligible vector so ptr sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    dbl       = {eligible, eligible} >> ptr_reg;
    rot       = dbl[NUM_CORES-1:0];
    gnt_valid = 1'b0;
    offset    = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_valid = 1'b1;
        offset    = CID_W'(i);
      end
    end
    sum    = {1'b0, ptr_reg} + {1'b0, offset};
    gnt_id = (sum >= NUM_CORES_W) ? CID_W'(sum - NUM_CORES_W) : CID_W'(sum);
    gnt    = '0;
    if (gnt_valid) gnt[gnt_id] = 1'b1;
    ptr_next = (gnt_id == LAST_ID) ? '0 : gnt_id + CID_W'(1);
  end

  assign wait_o = req_i & ~gnt;

`ifdef SHMEM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;

  state_t               state_reg;
  logic [CID_W-1:0]     owner_reg;
  logic [NUM_CORES-1:0] owner_mask;

  always_comb begin
    owner_mask            = '0;
    owner_mask[owner_reg] = 1'b1;
    eligible              = (state_reg == LOCKED) ? (req_i & owner_mask) : req_i;
    // ptr stays frozen for locked grants; the releasing grant moves it past the owner.
    ptr_update = gnt_valid & ~((state_reg == LOCKED) & lock_i[gnt_id]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB;
      owner_reg <= '0;
    end else begin
      case (state_reg)
        ARB: begin
          if (gnt_valid && lock_i[gnt_id]) begin
            state_reg <= LOCKED;
            owner_reg <= gnt_id;
          end
        end
        LOCKED: begin
          if (gnt_valid && !lock_i[gnt_id]) state_reg <= ARB;
        end
        default: state_reg <= ARB;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign eligible    = req_i;
  assign ptr_update  = gnt_valid;
`endif

  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_en_reg <= gnt_valid;
      mem_we_reg <= gnt_valid & we_i[gnt_id];
      if (gnt_valid) begin
        mem_addr_reg  <= addr_arr[gnt_id];
        mem_wdata_reg <= wdata_arr[gnt_id];
      end
      if (ptr_update) ptr_reg <= ptr_next;
    end
  end

  assign mem_en_o    = mem_en_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

  // Tag pipeline: stage 0 lines up with mem_en_o, stage RD_LAT with mem_rdata_i.
  logic             tag_vld_reg [NSTG];
  logic [CID_W-1:0] tag_id_reg  [NSTG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_reg[0] <= 1'b0;
      tag_id_reg[0]  <= '0;
    end else begin
      tag_vld_reg[0] <= gnt_valid & ~we_i[gnt_id];
      tag_id_reg[0]  <= gnt_id;
    end
  end

  generate
    for (genvar gi = 1; gi < NSTG; gi++) begin : g_tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_vld_reg[gi] <= 1'b0;
          tag_id_reg[gi]  <= '0;
        end else begin
          tag_vld_reg[gi] <= tag_vld_reg[gi-1];
          tag_id_reg[gi]  <= tag_id_reg[gi-1];
        end
      end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rvalid
      assign rvalid_o[gi] = tag_vld_reg[RD_LAT] && (tag_id_reg[RD_LAT] == CID_W'(gi));
    end
  endgenerate

  // Read data is forced to zero outside a valid return so reset and idle cycles read 0.
  assign rdata_o = tag_vld_reg[RD_LAT] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
// Self-checking bench for shared_mem_rr_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model (scoreboard of expected read returns).
module tb_shared_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int RL = 2;

  typedef struct {
    int            due;
    int            core;
    logic [DW-1:0] data;
  } rd_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_i, we_i, lock_i, wait_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic            mem_en_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;

  shared_mem_rr_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wait_o(wait_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // BRAM model with RL cycles of read latency.
  logic [DW-1:0] bram [256];
  logic [DW-1:0] bram_pipe [RL];
  bit            bram_ready = 1'b0;
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
      bram_ready <= 1'b1;
    end else if (mem_en_o && mem_we_o) begin
      bram[mem_addr_o[7:0]] <= mem_wdata_o;
    end
    bram_pipe[0] <= bram[mem_addr_o[7:0]];
    for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign mem_rdata_i = bram_pipe[RL-1];

  int checks = 0;
  int failures = 0;

  // Per-core requester state
  logic [N-1:0]  c_req = '0, c_we = '0, c_lock = '0;
  logic [AW-1:0] c_addr  [N];
  logic [DW-1:0] c_wdata [N];
  bit            auto_mode = 1'b0;

  // Reference model
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] ref_mem [256];
  rd_t           rq[$];

  logic [N-1:0]  s_wait, s_rvalid;
  logic [DW-1:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req_i  = c_req;
    we_i   = c_we;
    lock_i = c_lock;
    for (int k = 0; k < N; k++) begin
      addr_i[k*AW +: AW]  = c_addr[k];
      wdata_i[k*DW +: DW] = c_wdata[k];
    end
  endtask

  task automatic set_acc(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    c_req[k]   = 1'b1;
    c_we[k]    = we;
    c_addr[k]  = a;
    c_wdata[k] = d;
    c_lock[k]  = lk;
  endtask

  task automatic new_access(input int k);
    c_req[k]   = ($urandom_range(0, 99) < 60);
    c_we[k]    = 1'($urandom_range(0, 1));
    c_addr[k]  = AW'($urandom_range(0, 31));
    c_wdata[k] = $urandom;
    c_lock[k]  = ($urandom_range(0, 9) < 2);
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_locked  = 1'b0;
    m_owner   = 0;
    exp_en    = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    rq.delete();
  endtask

  task automatic do_reset();
    c_req = '0;
    apply();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mem_en", 64'(mem_en_o), 64'(0));
    chk("rst_mem_we", 64'(mem_we_o), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_rdata", 64'(rdata_o), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: check the DUT at negedge, then advance the model at posedge.
  task automatic step();
    logic [N-1:0]  elig, exp_wait, exp_rv;
    logic [DW-1:0] exp_rd;
    int            w, k, now;
    rd_t           e;
    apply();
    @(negedge clk);
    now  = cyc;
    elig = c_req;
`ifdef SHMEM_ARB_LOCK_EN
    if (m_locked) elig = c_req & (N'(1) << m_owner);
`endif
    w = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (w < 0 && elig[k]) w = k;
    end
    exp_wait = c_req;
    if (w >= 0) exp_wait[w] = 1'b0;
    chk("wait_o", 64'(wait_o), 64'(exp_wait));
    chk("mem_en_o", 64'(mem_en_o), 64'(exp_en));
    chk("mem_we_o", 64'(mem_we_o), 64'(exp_we));
    chk("mem_addr_o", 64'(mem_addr_o), 64'(exp_addr));
    chk("mem_wdata_o", 64'(mem_wdata_o), 64'(exp_wdata));
    exp_rv = '0;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == now) begin
      exp_rv[rq[0].core] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rvalid_o", 64'(rvalid_o), 64'(exp_rv));
    if (exp_rv != '0) chk("rdata_o", 64'(rdata_o), 64'(exp_rd));
    s_wait   = wait_o;
    s_rvalid = rvalid_o;
    s_rdata  = rdata_o;
    @(posedge clk);
    exp_en = (w >= 0);
    exp_we = 1'b0;
    if (w >= 0) begin
      exp_we    = c_we[w];
      exp_addr  = c_addr[w];
      exp_wdata = c_wdata[w];
      if (c_we[w]) begin
        ref_mem[c_addr[w][7:0]] = c_wdata[w];
      end else begin
        e.due  = now + 1 + RL;
        e.core = w;
        e.data = ref_mem[c_addr[w][7:0]];
        rq.push_back(e);
      end
`ifdef SHMEM_ARB_LOCK_EN
      if (m_locked) begin
        if (!c_lock[w]) begin
          m_locked = 1'b0;
          m_ptr    = (w + 1) % N;
        end
      end else begin
        m_ptr = (w + 1) % N;
        if (c_lock[w]) begin
          m_locked = 1'b1;
          m_owner  = w;
        end
      end
`else
      m_ptr = (w + 1) % N;
`endif
    end
    #1;
    for (int j = 0; j < N; j++) begin
      if (auto_mode) begin
        if (j == w || !c_req[j]) new_access(j);
      end else if (j == w) begin
        c_req[j] = 1'b0;
      end
    end
  endtask

  logic [N-1:0]  t2_exp [4];
  logic          seen;
  logic [DW-1:0] got;
  int            pos0, pos3;

  initial begin
    for (int k = 0; k < N; k++) begin
      c_addr[k]  = '0;
      c_wdata[k] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    apply();
    #2;
    do_reset();

    // Single requester: core0 loads 0x10 every cycle
    for (int i = 0; i < 6; i++) begin
      set_acc(0, 1'b0, AW'('h10), '0, 1'b0);
      step();
      chk("t1_wait", 64'(s_wait), 64'(0));
      chk("t1_rvalid0", 64'(s_rvalid[0]), 64'(i >= RL + 1));
    end
    repeat (5) step();

    // All four request from ptr=0
    do_reset();
    t2_exp[0] = 4'b1110; t2_exp[1] = 4'b1100; t2_exp[2] = 4'b1000; t2_exp[3] = 4'b0000;
    for (int k = 0; k < N; k++) set_acc(k, 1'b0, AW'('h20 + k), '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_wait", 64'(s_wait), 64'(t2_exp[i]));
    end
    repeat (5) step();

    // Store from core2 followed by load of the same word from core1
    set_acc(2, 1'b1, AW'('h5), 32'hDEAD_BEEF, 1'b0);
    step();
    set_acc(1, 1'b0, AW'('h5), '0, 1'b0);
    step();
    seen = 1'b0;
    got  = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_rvalid[1] && !seen) begin
        seen = 1'b1;
        got  = s_rdata;
      end
    end
    chk("t3_rvalid_seen", 64'(seen), 64'(1));
    chk("t3_rdata", 64'(got), 64'(32'hDEAD_BEEF));

    // Back-to-back loads from cores 0 and 3 return in grant order
    set_acc(0, 1'b1, AW'('h1), 32'hA, 1'b0); step();
    set_acc(3, 1'b1, AW'('h2), 32'hB, 1'b0); step();
    set_acc(0, 1'b0, AW'('h1), '0, 1'b0);    step();
    set_acc(3, 1'b0, AW'('h2), '0, 1'b0);    step();
    pos0 = -1;
    pos3 = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_rvalid[0] && pos0 < 0) begin
        pos0 = i;
        chk("t4_rdata0", 64'(s_rdata), 64'(32'hA));
      end
      if (s_rvalid[3] && pos3 < 0) begin
        pos3 = i;
        chk("t4_rdata3", 64'(s_rdata), 64'(32'hB));
      end
    end
    chk("t4_order", 64'(pos3 - pos0), 64'(1));

    // Random traffic
    auto_mode = 1'b1;
    for (int k = 0; k < N; k++) new_access(k);
    repeat (1500) step();
    auto_mode = 1'b0;
    c_req = '0;
    repeat (8) step();

    // Reset with two loads in flight
    set_acc(0, 1'b0, AW'('h3), '0, 1'b0); step();
    set_acc(1, 1'b0, AW'('h4), '0, 1'b0); step();
    do_reset();
    for (int k = 0; k < N; k++) set_acc(k, 1'b0, AW'('h8 + k), '0, 1'b0);
    step();
    chk("t5_first_gnt", 64'(s_wait), 64'(4'b1110));
    repeat (8) step();

`ifdef SHMEM_ARB_LOCK_EN
    // Locked read-modify-write by core1 while core0 keeps requesting
    do_reset();
    set_acc(1, 1'b0, AW'('h6), '0, 1'b1);
    step();
    set_acc(0, 1'b0, AW'('h7), '0, 1'b0);
    step();
    chk("t6_wait0_locked", 64'(s_wait[0]), 64'(1));
    set_acc(1, 1'b1, AW'('h6), 32'h1234_5678, 1'b0);
    step();
    chk("t6_wait0_release", 64'(s_wait[0]), 64'(1));
    step();
    chk("t6_wait0_granted", 64'(s_wait[0]), 64'(0));
    repeat (6) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
